uart_rx_ctrl: RTL and testbench

// Sequencing controller for the UART receive path. It synchronises the serial line,

---
 rtl/uart_rx_ctrl.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer.
// Synchronises the serial line, qualifies the start bit, samples each bit at
// mid-bit with a baud timer, checks parity and stop bit, and hands the byte
// to the consumer through a valid/ready handshake with error flags.
module uart_rx_ctrl #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 19_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BIT_TICKS = CLK_FREQ / BAUD;
    localparam int HALF      = BIT_TICKS / 2;
    localparam int TW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } state_t;

    state_t                state;
    logic                  rx_meta;
    logic                  rx_s;
    logic [TW-1:0]         timer;
    logic [2:0]            bitcnt;
    logic [DATA_BITS-1:0]  shift;
    logic                  par_bad;
    logic                  tick;

    // One full bit period has elapsed since the last sample point.
    assign tick = (timer == TICK_LAST);

    // Two-flop synchroniser; the line idles high so the flops reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // Frame sequencer, baud timer, shift register and output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            bitcnt     <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            busy       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Consume: the held frame is taken and any overrun is forgotten.
            // A commit further down on the same edge overrides rx_valid.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            // Free-running bit timer; states that need a fresh count clear it.
            timer <= tick ? '0 : timer + 1'b1;

            case (state)
                IDLE: begin
                    timer <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    // Half a bit in: a real start bit is still low here.
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        if (!rx_s) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        if (bitcnt == BIT_LAST) begin
                            state <= HAS_PAR ? PARITY : STOP;
                        end else begin
                            bitcnt <= bitcnt + 3'd1;
                        end
                    end
                end

                PARITY: begin
                    if (tick) begin
                        par_bad <= ((^shift) ^ rx_s) != ODD;
                        state   <= STOP;
                    end
                end

                STOP: begin
                    if (tick) begin
                        // Commit unless an unconsumed frame is still held.
                        if (!rx_valid || rx_ready) begin
                            rx_data    <= shift;
                            parity_err <= HAS_PAR ? par_bad : 1'b0;
                            frame_err  <= ~rx_s;
                            rx_valid   <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_HI;
                        end
                    end
                end

                WAIT_HI: begin
                    // A break or low stop bit must end before a new start is accepted.
                    timer <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int BT  = 16;
    localparam int LAT = 171 * 10 + 4;  // start-bit drive to presentation, in ns

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int ready_mode = 1;  // 0 = random consumer, 1 = driven by stimulus

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        time        t0;
    } exp_t;
    exp_t exp_q[$];

    uart_rx_ctrl #(
        .CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic good_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Serialise one frame; optionally record what the consumer must see.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                              input int stop_len, input bit push, input bit rdy_commit);
        exp_t e;
        @(posedge clk); #1;
        rx_in = 1'b0;
        if (push) begin
            int ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(d[i]);
            ones += int'(pbit);
            e.data = d;
            e.perr = (ones % 2 == 0);
            e.ferr = ~stopb;
            e.t0   = $time;
            exp_q.push_back(e);
        end
        repeat (BT) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (BT) @(posedge clk); #1;
        end
        rx_in = pbit;
        repeat (BT) @(posedge clk); #1;
        rx_in = stopb;
        if (rdy_commit) begin
            repeat (10) @(posedge clk); #1;
            rx_ready = 1'b1;
            @(posedge clk); #1;
            rx_ready = 1'b0;
            repeat (stop_len - 11) @(posedge clk); #1;
        end else begin
            repeat (stop_len) @(posedge clk); #1;
        end
        rx_in = 1'b1;
        repeat (2 * BT) @(posedge clk); #1;
    endtask

    task automatic consume_pulse();
        @(posedge clk); #1;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    // Random consumer.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) rx_ready = ($urandom_range(0, 3) == 0);
    end

    // Monitor: a frame is presented when rx_valid rises or stays high across a consume.
    logic prev_valid = 1'b0;
    logic prev_cons  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_cons  = 1'b0;
        end else begin
            if (rx_valid && (!prev_valid || prev_cons)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", int'(rx_data), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("frame data=%02h perr=%0b ferr=%0b (expect %02h %0b %0b)",
                             rx_data, parity_err, frame_err, e.data, e.perr, e.ferr);
                    chk("sb_data", int'(rx_data), int'(e.data));
                    chk("sb_parity_err", int'(parity_err), int'(e.perr));
                    chk("sb_frame_err", int'(frame_err), int'(e.ferr));
                    chk("sb_latency", int'($time - e.t0), LAT);
                end
            end
            prev_valid = rx_valid;
            prev_cons  = rx_valid && rx_ready;
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_flags", int'({parity_err, frame_err, overrun}), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;

        // 1: clean frame, consumer holds off, then a one-clock consume.
        send_frame(8'hA5, 1'b1, 1'b1, BT, 1, 0);
        chk("t1_valid_held", int'(rx_valid), 1);
        chk("t1_data_held", int'(rx_data), 8'hA5);
        consume_pulse();
        chk("t1_valid_dropped", int'(rx_valid), 0);

        // 2: short glitch rejected.
        @(posedge clk); #1;
        rx_in = 1'b0;
        repeat (4) @(posedge clk); #1;
        rx_in = 1'b1;
        chk("t2_busy_pulse", int'(busy), 1);
        repeat (20) @(posedge clk); #1;
        chk("t2_busy_idle", int'(busy), 0);
        chk("t2_no_valid", int'(rx_valid), 0);

        // 3: wrong parity bit.
        send_frame(8'h3C, 1'b0, 1'b1, BT, 1, 0);
        chk("t3_perr", int'(parity_err), 1);
        consume_pulse();

        // 4: stop bit held low (break); busy through the break, single frame.
        ready_mode = 0;
        fork
            send_frame(8'h00, 1'b1, 1'b0, 40, 1, 0);
            begin
                repeat (190) @(posedge clk); #1;
                chk("t4_busy_in_break", int'(busy), 1);
            end
        join
        chk("t4_busy_after", int'(busy), 0);

        // 5: overrun, then commit and consume on the same edge.
        ready_mode = 1;
        rx_ready   = 1'b0;
        send_frame(8'h11, good_par(8'h11), 1'b1, BT, 1, 0);
        send_frame(8'h22, good_par(8'h22), 1'b1, BT, 0, 0);
        chk("t5_overrun", int'(overrun), 1);
        chk("t5_data_kept", int'(rx_data), 8'h11);
        consume_pulse();
        chk("t5_overrun_clr", int'(overrun), 0);
        chk("t5_valid_clr", int'(rx_valid), 0);
        send_frame(8'h11, good_par(8'h11), 1'b1, BT, 1, 0);
        send_frame(8'h22, good_par(8'h22), 1'b1, BT, 1, 1);
        chk("t5b_no_overrun", int'(overrun), 0);
        chk("t5b_data", int'(rx_data), 8'h22);
        chk("t5b_valid", int'(rx_valid), 1);
        consume_pulse();

        // 6: reset in the middle of the data bits.
        @(posedge clk); #1;
        rx_in = 1'b0;
        repeat (BT) @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            rx_in = i[0];
            repeat (BT) @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_data", int'(rx_data), 0);
        chk("t6_rst_outs", int'({rx_valid, parity_err, frame_err, overrun}), 0);
        rx_in = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2 * BT) @(posedge clk); #1;
        ready_mode = 0;
        send_frame(8'h5A, good_par(8'h5A), 1'b1, BT, 1, 0);

        // Randomised frames with a random consumer.
        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            logic       bad;
            logic       stopb;
            d     = 8'($urandom_range(0, 255));
            bad   = ($urandom_range(0, 3) == 0);
            stopb = ($urandom_range(0, 4) != 0);
            send_frame(d, good_par(d) ^ bad, stopb,
                       stopb ? BT : int'($urandom_range(BT, 40)), 1, 0);
        end

        repeat (20) @(posedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
